counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 The block SHALL have one parameter: STOP_TMO, default 4, meaning the maximum cycles spent in STOP waiting for cnt_stop_d2 (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 2 bits: per-requester run request, level, held until that requester's done or abort.
REQ-005 The block SHALL have port len0, input, 4 bits: target count for requester 0, sampled at grant.
REQ-006 The block SHALL have port len1, input, 4 bits: target count for requester 1, sampled at grant.
REQ-007 The block SHALL have port gnt, output, 2 bits: one-hot grant, held from grant until return to IDLE.
REQ-008 The block SHALL have port done, output, 2 bits: one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port result, output, 4 bits: counter value captured at completion, held until the next capture.
REQ-010 The block SHALL have port err, output, 1 bit: sticky stop-timeout flag.
REQ-011 The block SHALL have ports cnt_rst, cnt_start and cnt_stop, each output, 1 bit: drive the shared counter's reset, start and stop inputs.
REQ-012 The block SHALL have ports cnt_count (input, 4 bits, counter value) and cnt_stop_d2 (input, 1 bit, counter's two-cycle-delayed stop acknowledge).

Function
REQ-013 The FSM SHALL have states IDLE, CLEAR, RUN, STOP, DONE.
REQ-014 In IDLE with any req bit set, the block SHALL grant on the next edge, go to CLEAR, and latch target = len of the winner.
REQ-015 Arbitration SHALL be round-robin: rr pointer names the preferred requester; if only one requests it wins; pointer moves to the other requester on leaving DONE.
REQ-016 In CLEAR the block SHALL assert cnt_rst for exactly one cycle; next state is RUN if target != 0, else STOP.
REQ-017 In RUN the block SHALL drive cnt_start=1 and cnt_stop=0, and SHALL go to STOP in the cycle after cnt_count == target is observed.
REQ-018 In STOP the block SHALL drive cnt_start=0 and cnt_stop=1 and run a 4-bit timeout counter cleared on STOP entry.
REQ-019 When cnt_stop_d2=1 in STOP, the block SHALL capture result=cnt_count and go to DONE.
REQ-020 When the timeout counter reaches STOP_TMO without cnt_stop_d2, the block SHALL set err, capture result=cnt_count, and go to DONE.
REQ-021 DONE SHALL last one cycle: done[granted]=1, gnt stays asserted; next state IDLE with gnt=0.
REQ-022 A granted requester dropping req in RUN (abort) SHALL cause a transition to STOP; completion then proceeds normally except that done is NOT pulsed and result is NOT updated.
REQ-023 The other requester's req arriving mid-run SHALL be ignored until IDLE; the earliest new grant is one cycle after DONE.
REQ-024 Outputs cnt_start, cnt_stop and cnt_rst SHALL be registered and mutually exclusive (at most one high).
REQ-025 The RUN compare SHALL be a 4-bit equality; the counter wrapping past 15 SHALL NOT occur because target <= 15 is reached first.

Reset
REQ-026 While rst=1, state=IDLE, gnt=0, done=0, result=0, err=0, cnt_start=0, cnt_stop=0, cnt_rst=1, rr=0, target=0, and the timeout counter=0.
REQ-027 Reset asserted mid-operation SHALL abort immediately with no done pulse; err SHALL clear only on rst.
REQ-028 The first cycle after reset release SHALL be IDLE with cnt_rst=0.

Verification
REQ-029 req=01, len0=5, well-behaved counter -> gnt=01, cnt_rst for 1 cycle, cnt_start until count=5, cnt_stop, done=01 one cycle, result=5.
REQ-030 req=11 held continuously, len0=3, len1=2 -> grants alternate 01, 10, 01; each done matches its grant; results 3, 2, 3.
REQ-031 len1=0, req=10 -> CLEAR then STOP with no cnt_start; done=10; result=0.
REQ-032 cnt_stop_d2 tied 0, STOP_TMO=4 -> 4 cycles in STOP, then err=1, done pulsed, err stays 1 across the next run.
REQ-033 req0 dropped at count=2 of len0=8 -> STOP, no done, result unchanged, IDLE afterwards.
REQ-034 rst pulsed during RUN -> all outputs at their reset values asynchronously; a fresh req afterwards completes normally.

Source files
------------

// File: rtl/counter_sched.sv
// Two-requester round-robin scheduler that sequences a shared counter through
// clear, run-to-target and stop-with-acknowledge, returning the captured count.
module counter_sched #(
  parameter int unsigned STOP_TMO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [3:0] result,
  output logic       err,
  output logic       cnt_rst,
  output logic       cnt_start,
  output logic       cnt_stop,
  input  logic [3:0] cnt_count,
  input  logic       cnt_stop_d2,
  output logic [2:0] dbg_state
);

  // Handshake: a requester holds req high until it sees done (or drops it to
  // abort); gnt is one-hot from the grant edge until the return to IDLE, and
  // done pulses for one cycle in DONE only for a run that was not aborted.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] TMO_LIM = 4'(STOP_TMO);

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [3:0] result_q, result_d;
  logic [3:0] target_q, target_d;
  logic [3:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       cnt_rst_q, cnt_rst_d;
  logic       cnt_start_q, cnt_start_d;
  logic       cnt_stop_q, cnt_stop_d;
  logic       rr_q, rr_d;
  logic       abort_q, abort_d;
  logic       win;
  logic       req_held;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    result_d    = result_q;
    target_d    = target_q;
    tmo_d       = 4'd0;
    err_d       = err_q;
    cnt_rst_d   = 1'b0;
    cnt_start_d = 1'b0;
    cnt_stop_d  = 1'b0;
    rr_d        = rr_q;
    abort_d     = abort_q;
    // rr_q only matters when both request; a lone requester always wins.
    win         = (req == 2'b11) ? rr_q : req[1];
    req_held    = gnt_q[1] ? req[1] : req[0];

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = CLEAR;
          gnt_d     = win ? 2'b10 : 2'b01;
          target_d  = win ? len1 : len0;
          cnt_rst_d = 1'b1;
          abort_d   = 1'b0;
        end
      end
      CLEAR: begin
        if (target_q != 4'd0) begin
          state_d     = RUN;
          cnt_start_d = 1'b1;
        end else begin
          state_d    = STOP;
          cnt_stop_d = 1'b1;
        end
      end
      RUN: begin
        if (!req_held) begin
          state_d    = STOP;
          cnt_stop_d = 1'b1;
          abort_d    = 1'b1;
        end else if (cnt_count == target_q) begin
          state_d    = STOP;
          cnt_stop_d = 1'b1;
        end else begin
          cnt_start_d = 1'b1;
        end
      end
      STOP: begin
        if (cnt_stop_d2 || (tmo_q + 4'd1 == TMO_LIM)) begin
          state_d = DONE;
          if (!cnt_stop_d2) err_d = 1'b1;
          if (!abort_q) begin
            result_d = cnt_count;
            done_d   = gnt_q;
          end
        end else begin
          tmo_d      = tmo_q + 4'd1;
          cnt_stop_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        rr_d    = ~gnt_q[1];
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      result_q    <= 4'd0;
      target_q    <= 4'd0;
      tmo_q       <= 4'd0;
      err_q       <= 1'b0;
      cnt_rst_q   <= 1'b1;
      cnt_start_q <= 1'b0;
      cnt_stop_q  <= 1'b0;
      rr_q        <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      target_q    <= target_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      cnt_rst_q   <= cnt_rst_d;
      cnt_start_q <= cnt_start_d;
      cnt_stop_q  <= cnt_stop_d;
      rr_q        <= rr_d;
      abort_q     <= abort_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign cnt_rst   = cnt_rst_q;
  assign cnt_start = cnt_start_q;
  assign cnt_stop  = cnt_stop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: a cycle-accurate shared-counter model plus a
// transaction-level reference for arbitration, result, done and err.
module tb_counter_sched;

  localparam int STOP_TMO = 4;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] gnt, done;
  logic [3:0] result;
  logic       err, cnt_rst, cnt_start, cnt_stop;
  logic [3:0] cnt_count;
  logic       cnt_stop_d2;
  logic [2:0] dbg_state;

  // shared counter model: reacts within the cycle its controls are driven
  logic [3:0] ctr;
  logic       s1, s2, stuck;

  int         checks = 0;
  int         errors = 0;
  int         rr_m = 0;
  logic       err_m = 1'b0;
  logic [3:0] res_m = 4'd0;
  logic [3:0] exp_q[$];

  counter_sched #(.STOP_TMO(STOP_TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .done(done), .result(result), .err(err),
    .cnt_rst(cnt_rst), .cnt_start(cnt_start), .cnt_stop(cnt_stop),
    .cnt_count(cnt_count), .cnt_stop_d2(cnt_stop_d2), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (cnt_rst) ctr <= 4'd0;
    else if (cnt_start) ctr <= ctr + 4'd1;
    s1 <= cnt_stop;
    s2 <= s1;
  end
  assign cnt_count   = ctr;
  assign cnt_stop_d2 = s2 & ~stuck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver + reference: one complete request from grant to the return to IDLE
  task automatic do_txn(input logic [1:0] rq, input logic [3:0] l0, input logic [3:0] l1,
                        input logic stk, input int abort_at, input logic keep);
    int         w, tgt, waitn, n, rst_n, start_n, stop_n, done_n, gnt_bad, mux_bad;
    logic [1:0] ghot, done_v;
    logic       seen, aborted;
    logic [3:0] e;
    w     = (rq == 2'b11) ? rr_m : (rq[1] ? 1 : 0);
    ghot  = (w == 1) ? 2'b10 : 2'b01;
    tgt   = (w == 1) ? int'(l1) : int'(l0);
    req   = rq;
    len0  = l0;
    len1  = l1;
    stuck = stk;
    waitn = 0;
    seen  = 1'b0;
    while (!seen && waitn < 8) begin
      @(posedge clk); #1;
      waitn++;
      seen = (gnt != 2'b00);
    end
    check("grant_latency", 32'(waitn), 32'd1);
    if (!seen) begin
      req = 2'b00;
      return;
    end
    exp_q.push_back(4'(tgt));
    check("grant_onehot", 32'(gnt), 32'(ghot));
    len0    = 4'($urandom_range(0, 15));
    len1    = 4'($urandom_range(0, 15));
    rst_n   = int'(cnt_rst);
    start_n = 0;
    stop_n  = 0;
    done_n  = 0;
    gnt_bad = 0;
    mux_bad = 0;
    done_v  = 2'b00;
    aborted = 1'b0;
    seen    = 1'b0;
    n       = 0;
    while (!seen && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (gnt == 2'b00) seen = 1'b1;
      else begin
        if (gnt != ghot) gnt_bad++;
        rst_n   += int'(cnt_rst);
        start_n += int'(cnt_start);
        stop_n  += int'(cnt_stop);
        if ($countones({cnt_rst, cnt_start, cnt_stop}) > 1) mux_bad++;
        if (done != 2'b00) begin
          done_n++;
          done_v = done;
          if (!keep) req = 2'b00;
        end
        if (abort_at >= 0 && !aborted && cnt_start && int'(cnt_count) == abort_at) begin
          if (w == 1) req[1] = 1'b0;
          else req[0] = 1'b0;
          aborted = 1'b1;
        end
      end
    end
    check("return_to_idle", 32'(seen), 32'd1);
    e     = exp_q.pop_front();
    err_m = err_m | stk;
    if (!aborted) res_m = e;
    check("gnt_held", 32'(gnt_bad), 32'd0);
    check("clear_cycles", 32'(rst_n), 32'd1);
    check("ctl_exclusive", 32'(mux_bad), 32'd0);
    if (abort_at < 0) check("run_cycles", 32'(start_n), 32'(tgt));
    check("stop_cycles", 32'(stop_n), stk ? 32'(STOP_TMO) : 32'd2);
    check("done_pulses", 32'(done_n), aborted ? 32'd0 : 32'd1);
    check("done_target", 32'(done_v), aborted ? 32'd0 : 32'(ghot));
    check("result", 32'(result), 32'(res_m));
    check("err", 32'(err), 32'(err_m));
    rr_m = 1 - w;
    if (!keep) req = 2'b00;
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    req   = 2'b00;
    len0  = 4'd0;
    len1  = 4'd0;
    stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ctl", 32'({cnt_rst, cnt_start, cnt_stop}), 32'b100);
    check("rst_state_idle", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_cnt_rst", 32'(cnt_rst), 32'd0);
    check("release_gnt", 32'(gnt), 32'd0);

    // single requester, target 5
    do_txn(2'b01, 4'd5, 4'd0, 1'b0, -1, 1'b0);
    // zero target skips RUN
    do_txn(2'b10, 4'd0, 4'd0, 1'b0, -1, 1'b0);
    // both requesting continuously: 01, 10, 01
    do_txn(2'b11, 4'd3, 4'd2, 1'b0, -1, 1'b1);
    do_txn(2'b11, 4'd3, 4'd2, 1'b0, -1, 1'b1);
    do_txn(2'b11, 4'd3, 4'd2, 1'b0, -1, 1'b0);
    // stuck acknowledge: timeout, sticky err across a later clean run
    do_txn(2'b01, 4'd7, 4'd0, 1'b1, -1, 1'b0);
    do_txn(2'b10, 4'd4, 4'd9, 1'b0, -1, 1'b0);
    // abort at count 2 of 8
    do_txn(2'b01, 4'd8, 4'd0, 1'b0, 2, 1'b0);
    do_txn(2'b01, 4'd15, 4'd1, 1'b0, -1, 1'b0);

    // reset in the middle of a run
    req   = 2'b01;
    len0  = 4'd9;
    stuck = 1'b0;
    n     = 0;
    while (!(cnt_start && cnt_count == 4'd3) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_mid_run", 32'(n < 20), 32'd1);
    rst = 1'b1;
    #1;
    res_m = 4'd0;
    err_m = 1'b0;
    rr_m  = 0;
    req   = 2'b00;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_result", 32'(result), 32'(res_m));
    check("async_rst_err", 32'(err), 32'(err_m));
    check("async_rst_ctl", 32'({cnt_rst, cnt_start, cnt_stop}), 32'b100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rerelease_cnt_rst", 32'(cnt_rst), 32'd0);
    do_txn(2'b11, 4'd6, 4'd2, 1'b0, -1, 1'b0);

    // randomized traffic against the reference
    for (int i = 0; i < 24; i++) begin
      do_txn(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 4) == 0), -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
